// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the half-bridge dead-time stage: state encoding and
// default dead-time counter width, reusable by a future bridge controller.
package pwm_deadtime_pkg;

  localparam int DT_WIDTH_DEFAULT = 4;

  // One-hot so every state decode is a single flop bit.
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_DT    = 5'b00010,
    S_LS_ON = 5'b00100,
    S_HS_ON = 5'b01000,
    S_FAULT = 5'b10000
  } dt_state_t;

endpackage

// File: rtl/pwm_deadtime_dt_counter.sv
// Dead-time down-counter: loads max(load_val,1)-1, decrements on request and
// flags zero, so a loaded value of 0 still yields one dead-time cycle.
module pwm_dt_counter #(
  parameter int DT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [DT_WIDTH-1:0] load_val,
  output logic                zero
);

  logic [DT_WIDTH-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? '0 : load_val - 1'b1;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time insertion stage: turns the single-ended PWM drive into
// complementary, never-overlapping high/low gate drives with a trip latch.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                trip,
  output logic                hs_out,
  output logic                ls_out,
  output logic                dt_active,
  output logic                fault
);

  dt_state_t state, next;
  logic      pwm_q;
  logic      cnt_load, cnt_dec, cnt_zero;

  // The generator output is decoded combinationally and may glitch, so only
  // this registered copy ever reaches the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q     <= 1'b0;
      state     <= S_IDLE;
      hs_out    <= 1'b0;
      ls_out    <= 1'b0;
      dt_active <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pwm_q     <= pwm_in;
      state     <= next;
      hs_out    <= (next == S_HS_ON);
      ls_out    <= (next == S_LS_ON);
      dt_active <= (next == S_DT);
      fault     <= (next == S_FAULT);
    end
  end

  // NOTE: next is defaulted before any branch so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next = state;
    if (trip) begin
      next = S_FAULT;
    end else if (state == S_FAULT) begin
      next = en ? S_FAULT : S_IDLE;
    end else if (!en) begin
      next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  next = S_DT;
        S_LS_ON: next = pwm_q ? S_DT : S_LS_ON;
        S_HS_ON: next = pwm_q ? S_HS_ON : S_DT;
        S_DT:    if (cnt_zero) next = pwm_q ? S_HS_ON : S_LS_ON;
        default: next = S_IDLE;
      endcase
    end
  end

  // dead_time is captured only on entry, so mid-gap changes wait for the next edge.
  assign cnt_load = (next == S_DT) && (state != S_DT);
  assign cnt_dec  = (next == S_DT) && (state == S_DT);

  pwm_dt_counter #(
    .DT_WIDTH(DT_WIDTH)
  ) u_dt_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (dead_time),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: a behavioural gate model predicts each
// cycle's outputs, a monitor compares them and checks overlap/dead-gap rules.
module tb_pwm_deadtime;
  import pwm_deadtime_pkg::*;

  localparam int DTW = DT_WIDTH_DEFAULT;

  typedef struct packed {
    logic hs;
    logic ls;
    logic dt;
    logic flt;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, en, pwm_in, trip;
  logic [DTW-1:0] dead_time;
  logic           hs_out, ls_out, dt_active, fault;

  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  exp_t exp_q[$];

  // Behavioural model: which gate is driven (0 none, 1 low, 2 high), how many
  // dead cycles remain, the latched fault and the one-cycle-late pwm copy.
  bit m_pwm_q = 0;
  bit m_fault = 0;
  int m_gap   = 0;
  int m_side  = 0;

  // Overlap / dead-gap tracking for the monitor.
  int last_on = 0;
  bit saw_dt  = 0;

  pwm_deadtime #(.DT_WIDTH(DTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_in    (pwm_in),
    .dead_time (dead_time),
    .trip      (trip),
    .hs_out    (hs_out),
    .ls_out    (ls_out),
    .dt_active (dt_active),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit r, input bit e, input bit p, input bit t, input int dt);
    bit prev;
    if (r) begin
      m_pwm_q = 0; m_fault = 0; m_gap = 0; m_side = 0;
    end else begin
      prev    = m_pwm_q;
      m_pwm_q = p;
      if (t) begin
        m_fault = 1; m_side = 0; m_gap = 0;
      end else if (m_fault) begin
        if (!e) m_fault = 0;
      end else if (!e) begin
        m_side = 0; m_gap = 0;
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) m_side = prev ? 2 : 1;
      end else if (m_side == 0 || (m_side == 1 && prev) || (m_side == 2 && !prev)) begin
        m_side = 0;
        m_gap  = (dt == 0) ? 1 : dt;
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit p, input bit t, input int dt);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; pwm_in = p; trip = t; dead_time = DTW'(dt);
    model_edge(r, e, p, t, dt);
    x.hs  = (m_side == 2);
    x.ls  = (m_side == 1);
    x.dt  = (m_gap > 0);
    x.flt = m_fault;
    exp_q.push_back(x);
    started = 1;
  endtask

  task automatic hold(input int n, input bit e, input bit p, input bit t, input int dt);
    for (int i = 0; i < n; i++) drive(1'b0, e, p, t, dt);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (started) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: DUT output with no expectation", $time);
      end else begin
        e = exp_q.pop_front();
        if ({hs_out, ls_out, dt_active, fault} !== e) begin
          errors++;
          $display("FAIL outputs at %0t: got hs/ls/dt/fault=%b, expected %b",
                   $time, {hs_out, ls_out, dt_active, fault}, e);
        end
      end
      checks++;
      if (hs_out === 1'b1 && ls_out === 1'b1) begin
        errors++;
        $display("FAIL overlap at %0t: hs_out=%b ls_out=%b, expected not both 1", $time, hs_out, ls_out);
      end
      if (rst) begin
        checks++;
        if ({hs_out, ls_out, dt_active, fault} !== 4'b0000) begin
          errors++;
          $display("FAIL after_reset at %0t: got %b, expected 0000",
                   $time, {hs_out, ls_out, dt_active, fault});
        end
      end
      if (dt_active) saw_dt = 1;
      if (hs_out ^ ls_out) begin
        if (last_on != 0 && last_on != (hs_out ? 2 : 1)) begin
          checks++;
          if (!saw_dt) begin
            errors++;
            $display("FAIL dead_gap at %0t: side changed to hs=%b with no dt_active cycle, expected a gap",
                     $time, hs_out);
          end
        end
        last_on = hs_out ? 2 : 1;
        saw_dt  = 0;
      end
    end
  end

  initial begin
    int hold_left;
    bit r_pwm, r_en;
    int r_dt;

    rst = 1'b1; en = 1'b0; pwm_in = 1'b0; trip = 1'b0; dead_time = '0;

    // Start-up with dead_time=3, then a 10-cycle high pulse and the fall.
    drive(1, 0, 0, 0, 3);
    drive(1, 0, 0, 0, 3);
    hold(8, 1, 0, 0, 3);
    hold(10, 1, 1, 0, 3);
    hold(10, 1, 0, 0, 3);

    // Minimum dead time: dead_time=0 behaves as a one-cycle gap.
    for (int k = 0; k < 4; k++) hold(4, 1, k[0] ? 1'b0 : 1'b1, 0, 0);
    hold(4, 1, 0, 0, 0);

    // Short pulse absorbed by a 5-cycle dead time.
    hold(8, 1, 0, 0, 5);
    hold(2, 1, 1, 0, 5);
    hold(10, 1, 0, 0, 5);

    // Trip while high side is on; fault holds until en drops, then restart.
    hold(10, 1, 1, 0, 3);
    hold(1, 1, 1, 1, 3);
    for (int k = 0; k < 6; k++) hold(1, 1, k[0], 0, 3);
    hold(2, 0, 0, 0, 3);
    hold(8, 1, 0, 0, 3);

    // Reset in the middle of a dead time.
    hold(1, 0, 0, 0, 6);
    hold(2, 1, 0, 0, 6);
    drive(1, 1, 0, 0, 6);
    hold(10, 1, 0, 0, 6);

    // Randomised traffic.
    r_pwm = 0; r_en = 1; r_dt = 3; hold_left = 0;
    for (int i = 0; i < 20000; i++) begin
      if (hold_left == 0) begin
        r_pwm     = ~r_pwm;
        hold_left = $urandom_range(1, 20);
      end
      hold_left--;
      if ($urandom_range(0, 99) == 0) r_dt = $urandom_range(0, 15);
      if ($urandom_range(0, 149) == 0) r_en = ~r_en;
      drive($urandom_range(0, 699) == 0, r_en, r_pwm, $urandom_range(0, 299) == 0, r_dt);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
